control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter CNT_WIDTH, default 32: width of the retired-instruction counter.
REQ-002 CLK  input  1  the only clock; all state changes on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 opcode  input  7  instruction[6:0] from the datapath instruction register.
REQ-005 mem_ready  input  1  memory completes the current read or write this cycle.
REQ-006 mem_re / mem_we  output  1 each  memory read request / memory write request.
REQ-007 WE_RF  output  1  register-file write enable.
REQ-008 RF_din_sel  output  2  register-file data source: 00 data_in, 01 ULA result, 10 primary PC adder (pc+4), 11 secondary PC adder (base+imm).
REQ-009 ULA_din2_sel  output  1  ULA operand 2 source: 1 immediate, 0 rs2.
REQ-010 addr_sel  output  1  memory address source: 1 pc, 0 ULA result.
REQ-011 load_pc, load_ir  output  1 each  PC load strobe, IR load strobe.
REQ-012 pc_next_sel  output  1  next-PC source: 0 primary adder, 1 secondary adder.
REQ-013 pc_adder_sel  output  1  secondary-adder base: 0 pc, 1 rs1.
REQ-014 branch  output  1  PC update is conditional on the datapath flags and funct3.
REQ-015 instret  output  CNT_WIDTH  count of retired instructions.

Function
REQ-016 The FSM SHALL have the states FETCH, DECODE, EXEC and MEM; all outputs SHALL be combinational decodes of state and opcode.
REQ-017 Any output not listed for a state SHALL be 0, except addr_sel, which SHALL be 1 outside MEM.
REQ-018 In FETCH the FSM SHALL assert mem_re with addr_sel=1 and hold there until mem_ready; in the mem_ready cycle it SHALL assert load_ir and go to DECODE.
REQ-019 DECODE SHALL last exactly one cycle with no strobes, then go to EXEC.
REQ-020 EXEC for OP (0110011) SHALL assert WE_RF, RF_din_sel=01, ULA_din2_sel=0 and load_pc with pc_next_sel=0, then go to FETCH.
REQ-021 EXEC for OP-IMM (0010011) and LUI (0110111) SHALL behave as OP but with ULA_din2_sel=1.
REQ-022 EXEC for AUIPC (0010111) SHALL assert WE_RF, RF_din_sel=11, pc_adder_sel=0 and load_pc with pc_next_sel=0.
REQ-023 EXEC for JAL (1101111) SHALL assert WE_RF, RF_din_sel=10 and load_pc with pc_next_sel=1 and pc_adder_sel=0.
REQ-024 EXEC for JALR (1100111) SHALL behave as JAL but with pc_adder_sel=1.
REQ-025 EXEC for BRANCH (1100011) SHALL assert load_pc, branch=1, pc_next_sel=1, pc_adder_sel=0 and ULA_din2_sel=0, then go to FETCH.
REQ-026 EXEC for LOAD (0000011) and STORE (0100011) SHALL go to MEM with no strobes.
REQ-027 MEM SHALL drive addr_sel=0 and ULA_din2_sel=1 and assert mem_re (LOAD) or mem_we (STORE) until mem_ready.
REQ-028 In the mem_ready cycle, a LOAD SHALL additionally assert WE_RF with RF_din_sel=00; both LOAD and STORE SHALL assert load_pc with pc_next_sel=0 and go to FETCH.
REQ-029 Latency with zero-wait memory SHALL be 3 cycles per instruction (4 for LOAD/STORE); each wait cycle SHALL add one cycle.
REQ-030 instret SHALL increment by 1 on every cycle in which load_pc=1 and SHALL wrap modulo 2^CNT_WIDTH.
REQ-031 An unrecognised opcode in EXEC SHALL assert load_pc with pc_next_sel=0 only (a NOP), unless ILLEGAL_TRAP_EN is defined.

Reset
REQ-032 reset SHALL force state FETCH and instret to 0 on the next edge, overriding mem_ready and any pending transition, including mid-wait in FETCH or MEM.
REQ-033 While reset is high, all strobes (mem_re, mem_we, WE_RF, load_pc, load_ir) SHALL be 0.

Configuration
REQ-034 With ILLEGAL_TRAP_EN defined, an unrecognised opcode in EXEC SHALL enter a HALT state that asserts output illegal=1 and no strobes, and leaves only on reset.
REQ-035 Without ILLEGAL_TRAP_EN, the HALT state and the illegal port SHALL be absent and REQ-031 SHALL apply.

Structure
REQ-036 The opcode constants and the state enum SHALL live in the shared package riscv_pkg.
REQ-037 The instret counter SHALL be the sub-module instret_counter; all other logic SHALL be flat.

Verification
REQ-038 reset=1 for 2 cycles, then 0 with mem_ready=1 -> FETCH asserts mem_re=1 and addr_sel=1 on the first cycle; instret=0.
REQ-039 OP instruction, mem_ready tied to 1 -> load_ir at cycle 1, WE_RF=1 with RF_din_sel=01 at cycle 3; instret=1.
REQ-040 LOAD with mem_ready low for 3 cycles in MEM -> mem_re held for 4 cycles, then WE_RF=1 with RF_din_sel=00 and load_pc in the same cycle.
REQ-041 JALR -> WE_RF=1, RF_din_sel=10, pc_next_sel=1, pc_adder_sel=1; BRANCH -> branch=1 with WE_RF=0.
REQ-042 Reset asserted during a MEM wait of a STORE -> mem_we drops to 0 the next cycle and no load_pc is issued.
REQ-043 opcode 1111111 -> NOP with instret incremented; with ILLEGAL_TRAP_EN, illegal=1 held until reset.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared opcode constants and control FSM state encoding.
// ILLEGAL_TRAP_EN adds the HALT state used by the illegal-opcode trap.
package riscv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

`ifdef ILLEGAL_TRAP_EN
  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_HALT
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM
  } state_t;
`endif

  function automatic logic opc_known(input logic [6:0] op);
    case (op)
      OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
      OPC_BRANCH, OPC_LOAD, OPC_STORE: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instret_counter.sv
// Retired-instruction counter: increments once per PC load, wraps at 2^W.
module instret_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (inc)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle RISC-V control FSM (FETCH/DECODE/EXEC/MEM) with combinational decodes.
// Define ILLEGAL_TRAP_EN to trap unknown opcodes into HALT with an illegal output.
module control_unit
  import riscv_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic                 mem_ready,
  output logic                 mem_re,
  output logic                 mem_we,
  output logic                 WE_RF,
  output logic [1:0]           RF_din_sel,
  output logic                 ULA_din2_sel,
  output logic                 addr_sel,
  output logic                 load_pc,
  output logic                 load_ir,
  output logic                 pc_next_sel,
  output logic                 pc_adder_sel,
  output logic                 branch,
  output logic [CNT_WIDTH-1:0] instret,
`ifdef ILLEGAL_TRAP_EN
  output logic                 illegal,
`endif
  output state_t               dbg_state
);

  state_t state;
  logic   is_load, is_store;

  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign dbg_state = state;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= ST_FETCH;
    end else begin
      case (state)
        ST_FETCH:  if (mem_ready) state <= ST_DECODE;
        ST_DECODE: state <= ST_EXEC;
        ST_EXEC: begin
          if (is_load || is_store)
            state <= ST_MEM;
`ifdef ILLEGAL_TRAP_EN
          else if (!opc_known(opcode))
            state <= ST_HALT;
`endif
          else
            state <= ST_FETCH;
        end
        ST_MEM:    if (mem_ready) state <= ST_FETCH;
`ifdef ILLEGAL_TRAP_EN
        ST_HALT:   state <= ST_HALT;
`endif
        default:   state <= ST_FETCH;
      endcase
    end
  end

  always_comb begin
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    WE_RF        = 1'b0;
    RF_din_sel   = 2'b00;
    ULA_din2_sel = 1'b0;
    addr_sel     = 1'b1;
    load_pc      = 1'b0;
    load_ir      = 1'b0;
    pc_next_sel  = 1'b0;
    pc_adder_sel = 1'b0;
    branch       = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    illegal      = 1'b0;
`endif
    case (state)
      ST_FETCH: begin
        mem_re  = 1'b1;
        load_ir = mem_ready;
      end
      ST_EXEC: begin
        case (opcode)
          OPC_OP: begin
            WE_RF = 1'b1; RF_din_sel = 2'b01; load_pc = 1'b1;
          end
          OPC_OP_IMM, OPC_LUI: begin
            WE_RF = 1'b1; RF_din_sel = 2'b01; ULA_din2_sel = 1'b1; load_pc = 1'b1;
          end
          OPC_AUIPC: begin
            WE_RF = 1'b1; RF_din_sel = 2'b11; load_pc = 1'b1;
          end
          OPC_JAL, OPC_JALR: begin
            WE_RF = 1'b1; RF_din_sel = 2'b10; load_pc = 1'b1; pc_next_sel = 1'b1;
            pc_adder_sel = (opcode == OPC_JALR);
          end
          OPC_BRANCH: begin
            load_pc = 1'b1; branch = 1'b1; pc_next_sel = 1'b1;
          end
          OPC_LOAD, OPC_STORE: ;
`ifdef ILLEGAL_TRAP_EN
          default: ;
`else
          default: load_pc = 1'b1;
`endif
        endcase
      end
      ST_MEM: begin
        addr_sel     = 1'b0;
        ULA_din2_sel = 1'b1;
        mem_re       = is_load;
        mem_we       = is_store;
        if (mem_ready) begin
          WE_RF   = is_load;
          load_pc = 1'b1;
        end
      end
`ifdef ILLEGAL_TRAP_EN
      ST_HALT: illegal = 1'b1;
`endif
      default: ;
    endcase
    // Reset may land mid-wait; no side effect may escape in that cycle.
    if (reset) begin
      mem_re  = 1'b0;
      mem_we  = 1'b0;
      WE_RF   = 1'b0;
      load_pc = 1'b0;
      load_ir = 1'b0;
    end
  end

  instret_counter #(.W(CNT_WIDTH)) u_instret (
    .clk   (CLK),
    .reset (reset),
    .inc   (load_pc),
    .count (instret)
  );

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: drivers push per-cycle expected output
// vectors into exp_q, a negedge monitor pops and compares them.
module tb_control_unit;
  import riscv_pkg::*;

  localparam int CW = 4;
  localparam int W  = 13 + CW;

  logic          CLK = 1'b0;
  logic          reset;
  logic [6:0]    opcode;
  logic          mem_ready;
  logic          mem_re, mem_we, WE_RF, ULA_din2_sel, addr_sel;
  logic          load_pc, load_ir, pc_next_sel, pc_adder_sel, branch;
  logic [1:0]    RF_din_sel;
  logic [CW-1:0] instret;
  logic          illegal_w;
  state_t        dbg_state;

  logic [W-1:0]  exp_q[$];
  logic [CW-1:0] exp_cnt;
  int            errors = 0;
  int            checks = 0;

  control_unit #(.CNT_WIDTH(CW)) dut (
    .CLK          (CLK),
    .reset        (reset),
    .opcode       (opcode),
    .mem_ready    (mem_ready),
    .mem_re       (mem_re),
    .mem_we       (mem_we),
    .WE_RF        (WE_RF),
    .RF_din_sel   (RF_din_sel),
    .ULA_din2_sel (ULA_din2_sel),
    .addr_sel     (addr_sel),
    .load_pc      (load_pc),
    .load_ir      (load_ir),
    .pc_next_sel  (pc_next_sel),
    .pc_adder_sel (pc_adder_sel),
    .branch       (branch),
    .instret      (instret),
`ifdef ILLEGAL_TRAP_EN
    .illegal      (illegal_w),
`endif
    .dbg_state    (dbg_state)
  );

`ifndef ILLEGAL_TRAP_EN
  assign illegal_w = 1'b0;
`endif

  // Clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: run still active at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // Expected vector layout: {illegal, mem_re, mem_we, WE_RF, RF_din_sel,
  // ULA_din2_sel, addr_sel, load_pc, load_ir, pc_next_sel, pc_adder_sel, branch, instret}
  function automatic logic [W-1:0] v(input logic mre, mwe, we, input logic [1:0] rf,
                                     input logic ula, adr, lpc, lir, pns, pas, br, ill);
    return {ill, mre, mwe, we, rf, ula, adr, lpc, lir, pns, pas, br, exp_cnt};
  endfunction

  function automatic logic [W-1:0] exec_vec(input logic [6:0] op);
    case (op)
      OPC_OP:              return v(0,0,1,2'b01,0,1,1,0,0,0,0,0);
      OPC_OP_IMM, OPC_LUI: return v(0,0,1,2'b01,1,1,1,0,0,0,0,0);
      OPC_AUIPC:           return v(0,0,1,2'b11,0,1,1,0,0,0,0,0);
      OPC_JAL:             return v(0,0,1,2'b10,0,1,1,0,1,0,0,0);
      OPC_JALR:            return v(0,0,1,2'b10,0,1,1,0,1,1,0,0);
      OPC_BRANCH:          return v(0,0,0,2'b00,0,1,1,0,1,0,1,0);
      OPC_LOAD, OPC_STORE: return v(0,0,0,2'b00,0,1,0,0,0,0,0,0);
`ifdef ILLEGAL_TRAP_EN
      default:             return v(0,0,0,2'b00,0,1,0,0,0,0,0,0);
`else
      default:             return v(0,0,0,2'b00,0,1,1,0,0,0,0,0);
`endif
    endcase
  endfunction

  // Driver tasks
  task automatic push(input logic [W-1:0] x);
    exp_q.push_back(x);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic front(input logic [6:0] op, input int fw);
    opcode = op;
    for (int i = 0; i < fw; i++) begin
      mem_ready = 1'b0;
      push(v(1,0,0,2'b00,0,1,0,0,0,0,0,0));
      step();
    end
    mem_ready = 1'b1;
    push(v(1,0,0,2'b00,0,1,0,1,0,0,0,0));
    step();
    mem_ready = 1'($urandom_range(0, 1));
    push(v(0,0,0,2'b00,0,1,0,0,0,0,0,0));
    step();
  endtask

  task automatic run_instr(input logic [6:0] op, input int fw, input int mw);
    logic ld, st, retire;
    ld = (op == OPC_LOAD);
    st = (op == OPC_STORE);
`ifdef ILLEGAL_TRAP_EN
    retire = !ld && !st && opc_known(op);
`else
    retire = !ld && !st;
`endif
    front(op, fw);
    mem_ready = 1'($urandom_range(0, 1));
    push(exec_vec(op));
    if (retire) exp_cnt++;
    step();
    if (ld || st) begin
      for (int i = 0; i < mw; i++) begin
        mem_ready = 1'b0;
        push(v(ld,st,0,2'b00,1,0,0,0,0,0,0,0));
        step();
      end
      mem_ready = 1'b1;
      push(v(ld,st,ld,2'b00,1,0,1,0,0,0,0,0));
      exp_cnt++;
      step();
    end
  endtask

  // Monitor / scoreboard
  always @(negedge CLK) begin
    logic [W-1:0] obs, exp;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      obs = {illegal_w, mem_re, mem_we, WE_RF, RF_din_sel, ULA_din2_sel, addr_sel,
             load_pc, load_ir, pc_next_sel, pc_adder_sel, branch, instret};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL outputs @%0t op=%b state=%0d: got %b required %b",
                 $time, opcode, dbg_state, obs, exp);
      end
    end
  end

  logic [6:0] mix [9];

  initial begin
    mix = '{OPC_OP, OPC_LOAD, OPC_JAL, OPC_STORE, OPC_OP_IMM,
            OPC_BRANCH, OPC_AUIPC, OPC_JALR, OPC_LUI};
    exp_cnt   = '0;
    reset     = 1'b1;
    mem_ready = 1'b0;
    opcode    = 7'd0;
    step();
    // Second reset cycle: FETCH state, strobes held off
    mem_ready = 1'b1;
    push(v(0,0,0,2'b00,0,1,0,0,0,0,0,0));
    step();
    reset = 1'b0;

    run_instr(OPC_OP,     0, 0);
    run_instr(OPC_OP_IMM, 1, 0);
    run_instr(OPC_LUI,    0, 0);
    run_instr(OPC_AUIPC,  0, 0);
    run_instr(OPC_JAL,    0, 0);
    run_instr(OPC_JALR,   0, 0);
    run_instr(OPC_BRANCH, 0, 0);
    run_instr(OPC_LOAD,   0, 3);
    run_instr(OPC_STORE,  0, 0);
    run_instr(OPC_LOAD,   2, 0);
    run_instr(7'b1111111, 0, 0);

`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      push(v(0,0,0,2'b00,0,1,0,0,0,0,0,1));
      step();
    end
    reset = 1'b1;
    push(v(0,0,0,2'b00,0,1,0,0,0,0,0,1));
    step();
    exp_cnt = '0;
    reset   = 1'b0;
`endif

    // Reset lands during a STORE memory wait
    front(OPC_STORE, 0);
    push(exec_vec(OPC_STORE));
    step();
    for (int i = 0; i < 2; i++) begin
      mem_ready = 1'b0;
      push(v(0,1,0,2'b00,1,0,0,0,0,0,0,0));
      step();
    end
    reset     = 1'b1;
    mem_ready = 1'b1;
    push(v(0,0,0,2'b00,1,0,0,0,0,0,0,0));
    step();
    exp_cnt = '0;
    reset   = 1'b0;

    // Mixed sequence long enough to wrap the 4-bit counter
    for (int i = 0; i < 18; i++)
      run_instr(mix[i % 9], $urandom_range(0, 1), $urandom_range(0, 2));

    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
